// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage sequencer for a 16-bit little-endian data memory; byte stores run as read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned word accesses instead of performing them.
module load_store_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_W   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [1:0]        reqSize,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqWData,
    input  logic [RD_W-1:0]   reqRd,
    output logic              respValid,
    output logic [DATA_W-1:0] respData,
    output logic [RD_W-1:0]   respRd,
    output logic              respErr,
    output logic              memWrEnable,
    output logic              memRdEnable,
    output logic [1:0]        memNumberOfByte,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memIn,
    input  logic [DATA_W-1:0] memOut
);
    typedef enum logic [2:0] {IDLE, LD_RD, LD_CAP, RESP, ST_WR, RMW_RD, RMW_CAP, RMW_WR} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, merge_q, resp_data_q, load_ext;
    logic [1:0]        size_q, size_n;
    logic [RD_W-1:0]   rd_q, resp_rd_q;
    logic              resp_err_q, accept, trap;

    assign size_n   = (reqSize == 2'b11) ? 2'b00 : reqSize;
    assign reqReady = (state_q == IDLE) & reset_n;
    assign accept   = reqValid & reqReady;
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = accept & (size_n == 2'b00) & reqAddr[0];
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = trap ? RESP : !reqWrite ? LD_RD : (size_n == 2'b00) ? ST_WR : RMW_RD;
            LD_RD:   state_d = LD_CAP;
            LD_CAP:  state_d = RESP;
            RMW_RD:  state_d = RMW_CAP;
            RMW_CAP: state_d = RMW_WR;
            default: state_d = IDLE;
        endcase
    end

    // Byte loads extend the low byte here so the result never depends on how the memory fills the upper byte.
    assign load_ext = (size_q == 2'b01) ? {{(DATA_W-8){1'b0}}, memOut[7:0]} :
                      (size_q == 2'b10) ? {{(DATA_W-8){memOut[7]}}, memOut[7:0]} : memOut;

    assign memRdEnable     = reset_n & ((state_q == LD_RD) | (state_q == RMW_RD));
    assign memWrEnable     = reset_n & ((state_q == ST_WR) | (state_q == RMW_WR));
    assign memNumberOfByte = (state_q == LD_RD) ? size_q : 2'b00;
    assign memAddress      = (state_q == IDLE) ? '0 : addr_q;
    assign memIn           = (state_q == ST_WR) ? wdata_q : (state_q == RMW_WR) ? merge_q : '0;
    assign respValid       = (state_q == RESP);
    assign respData        = resp_data_q;
    assign respRd          = resp_rd_q;
    assign respErr         = resp_err_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            rd_q        <= '0;
            merge_q     <= '0;
            resp_data_q <= '0;
            resp_rd_q   <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= reqAddr;
                wdata_q <= reqWData;
                size_q  <= size_n;
                rd_q    <= reqRd;
            end
            if (trap) begin
                resp_data_q <= '0;
                resp_rd_q   <= reqRd;
                resp_err_q  <= 1'b1;
            end
            if (state_q == LD_CAP) begin
                resp_data_q <= load_ext;
                resp_rd_q   <= rd_q;
                resp_err_q  <= 1'b0;
            end
            if (state_q == RMW_CAP) merge_q <= {memOut[DATA_W-1:8], wdata_q[7:0]};
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit against a byte-array memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset_n, reqValid, reqReady, reqWrite, respValid, respErr, memWrEnable, memRdEnable;
    logic [1:0]  reqSize, memNumberOfByte;
    logic [15:0] reqAddr, reqWData, respData, memAddress, memIn, memOut;
    logic [2:0]  reqRd, respRd;
    logic [7:0]  mem [0:65535];
    int          checks = 0, errors = 0, rd_cnt = 0, wr_cnt = 0, ovl = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset_n(reset_n), .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqAddr(reqAddr), .reqWData(reqWData), .reqRd(reqRd),
        .respValid(respValid), .respData(respData), .respRd(respRd), .respErr(respErr),
        .memWrEnable(memWrEnable), .memRdEnable(memRdEnable), .memNumberOfByte(memNumberOfByte),
        .memAddress(memAddress), .memIn(memIn), .memOut(memOut)
    );

    always @(posedge clk) begin
        if (memWrEnable) begin
            mem[memAddress]         <= memIn[7:0];
            mem[memAddress + 16'd1] <= memIn[15:8];
            wr_cnt++;
        end
        if (memRdEnable) begin
            memOut <= {mem[memAddress + 16'd1], mem[memAddress]};
            rd_cnt++;
        end
    end

    always @(negedge clk) if (memWrEnable && memRdEnable) ovl++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic [15:0] a, input logic [15:0] d,
                         input logic [2:0] rd);
        int n;
        reqWrite = w; reqSize = sz; reqAddr = a; reqWData = d; reqRd = rd; reqValid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!reqReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready", reqReady, 1);
        @(posedge clk);
        #1 reqValid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        @(negedge clk);
        while (!respValid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("resp_seen", respValid, 1);
    endtask

    task automatic load(input string tag, input logic [1:0] sz, input logic [15:0] a, input logic [2:0] rd,
                        input logic [15:0] exp);
        int lat;
        issue(1'b0, sz, a, 16'h0, rd);
        wait_resp(lat);
        check({tag, "_lat"}, lat, 3);
        check({tag, "_data"}, respData, exp);
        check({tag, "_rd"}, respRd, rd);
        check({tag, "_err"}, respErr, 0);
    endtask

    initial begin
        int lat, w0, r0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        reset_n = 1'b0; reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b00;
        reqAddr = 16'h0; reqWData = 16'h0; reqRd = 3'd0;
        repeat (2) begin
            @(negedge clk);
            check("rst_ready", reqReady, 0);
            check("rst_wr", memWrEnable, 0);
            check("rst_rd", memRdEnable, 0);
            check("rst_valid", respValid, 0);
        end
        check("rst_data", respData, 0);
        reset_n = 1'b1; reqValid = 1'b0;
        @(negedge clk);
        check("idle_addr", memAddress, 0);

        issue(1'b1, 2'b00, 16'h0010, 16'hBEEF, 3'd0);
        @(negedge clk);
        check("st_wr", memWrEnable, 1);
        check("st_addr", memAddress, 16'h0010);
        check("st_in", memIn, 16'hBEEF);
        load("ldw", 2'b00, 16'h0010, 3'd5, 16'hBEEF);
        @(negedge clk);
        check("pulse_end", respValid, 0);
        check("hold_data", respData, 16'hBEEF);
        check("hold_rd", respRd, 5);

        issue(1'b1, 2'b01, 16'h0010, 16'h0080, 3'd0);
        load("ld00", 2'b00, 16'h0010, 3'd1, 16'hBE80);
        load("ld01", 2'b01, 16'h0010, 3'd2, 16'h0080);
        load("ld10", 2'b10, 16'h0010, 3'd4, 16'hFF80);
        load("ld11", 2'b11, 16'h0010, 3'd7, 16'hBE80);

        @(negedge clk);
        reqWrite = 1'b0; reqSize = 2'b00; reqAddr = 16'h0010; reqRd = 3'd1; reqValid = 1'b1;
        check("b2b_c0", reqReady, 1);
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("b2b_busy", reqReady, 0);
        end
        check("b2b_valid", respValid, 1);
        check("b2b_rd1", respRd, 1);
        @(negedge clk);
        check("b2b_c4", reqReady, 1);
        reqRd = 3'd2;
        @(posedge clk);
        #1 reqValid = 1'b0;
        wait_resp(lat);
        check("b2b_lat", lat, 3);
        check("b2b_rd2", respRd, 2);

        issue(1'b1, 2'b01, 16'h0010, 16'h0011, 3'd0);
        @(negedge clk);
        check("rmw_rd", memRdEnable, 1);
        @(negedge clk);
        w0 = wr_cnt;
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_wr", memWrEnable, 0);
        reset_n = 1'b1;
        #1;
        check("abort_idle", reqReady, 1);
        check("abort_nowr", wr_cnt - w0, 0);
        check("abort_data", respData, 0);
        load("after_abort", 2'b00, 16'h0010, 3'd6, 16'hBE80);

        issue(1'b1, 2'b00, 16'h0012, 16'hAB12, 3'd0);
        @(negedge clk);
        r0 = rd_cnt;
        issue(1'b0, 2'b00, 16'h0011, 16'h0, 3'd3);
        wait_resp(lat);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_lat", lat, 1);
        check("mis_err", respErr, 1);
        check("mis_data", respData, 0);
        check("mis_rdcnt", rd_cnt - r0, 0);
`else
        check("mis_lat", lat, 3);
        check("mis_err", respErr, 0);
        check("mis_data", respData, 16'h12BE);
        check("mis_rdcnt", rd_cnt - r0, 1);
`endif
        check("mis_rd", respRd, 3);
        check("no_overlap", ovl, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
